// File: rtl/writeback_pipe.sv
// Registered writeback stage: selects ALU or formatted load data, waits for late
// memory data, and drives the register-file write port with a one-cycle write pulse.
module writeback_pipe #(
    parameter int unsigned ADDR_SIZE  = 5,
    parameter int unsigned WORD_SIZE  = 32,
    parameter int unsigned BIG_ENDIAN = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WORD_SIZE-1:0] alu_data,
    input  logic                 rd_data_sel,
    input  logic [1:0]           load_size,
    input  logic                 load_unsigned,
    input  logic [ADDR_SIZE-1:0] rd_addr_in,
    input  logic                 reg_write_in,
    input  logic [WORD_SIZE-1:0] mem_data,
    input  logic                 mem_valid,
    output logic                 rd_we,
    output logic [ADDR_SIZE-1:0] rd_addr,
    output logic [WORD_SIZE-1:0] rd_data,
    output logic                 addr_err
);

    generate
        if (WORD_SIZE != 32) begin : g_word_size_check
            $error("writeback_pipe: WORD_SIZE must be 32");
        end
    endgenerate

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;

    logic [1:0]             r_off;
    logic [1:0]             r_size;
    logic                   r_uns;
    logic [ADDR_SIZE-1:0]   r_addr;
    logic                   r_wr;

    logic                   w_accept;
    logic                   w_capture;
    logic                   w_done;
    logic                   w_load;
    logic [1:0]             w_off;
    logic [1:0]             w_size;
    logic                   w_uns;
    logic [ADDR_SIZE-1:0]   w_addr;
    logic                   w_wr;
    logic                   w_mis;
    logic [WORD_SIZE-1:0]   w_result;

    // Shift the addressed lane down to bit 0, then extend.
    function automatic logic [WORD_SIZE-1:0] format_load(
        input logic [WORD_SIZE-1:0] word,
        input logic [1:0]           off,
        input logic [1:0]           size,
        input logic                 uns
    );
        logic [1:0]           lane;
        logic [4:0]           amt;
        logic [WORD_SIZE-1:0] sh;
        logic [WORD_SIZE-1:0] res;
        lane = (BIG_ENDIAN != 0) ? ~off : off;
        case (size)
            SZ_BYTE: amt = {lane, 3'b000};
            SZ_HALF: amt = {lane[1], 4'b0000};
            default: amt = 5'd0;
        endcase
        sh = word >> amt;
        case (size)
            SZ_BYTE: res = uns ? {24'h0, sh[7:0]}  : {{24{sh[7]}}, sh[7:0]};
            SZ_HALF: res = uns ? {16'h0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
            default: res = word;
        endcase
        return res;
    endfunction

    assign in_ready  = (r_state == S_IDLE);
    assign w_accept  = in_valid & in_ready & ~flush;
    assign w_capture = w_accept & rd_data_sel & ~mem_valid;

    // Next state and selection of the completing instruction's fields.
    always_comb begin
        w_state_nxt = r_state;
        w_done      = 1'b0;
        w_load      = rd_data_sel;
        w_off       = alu_data[1:0];
        w_size      = load_size;
        w_uns       = load_unsigned;
        w_addr      = rd_addr_in;
        w_wr        = reg_write_in;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if (rd_data_sel && !mem_valid) begin
                        w_state_nxt = S_WAIT;
                    end else begin
                        w_done = 1'b1;
                    end
                end
            end
            S_WAIT: begin
                w_load = 1'b1;
                w_off  = r_off;
                w_size = r_size;
                w_uns  = r_uns;
                w_addr = r_addr;
                w_wr   = r_wr;
                if (flush) begin
                    w_state_nxt = S_IDLE;
                end else if (mem_valid) begin
                    w_done      = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign w_mis    = w_load & (((w_size == SZ_HALF) & w_off[0]) |
                                (w_size[1] & (w_off != 2'b00)));
    assign w_result = w_load ? format_load(mem_data, w_off, w_size, w_uns) : alu_data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Fields of a load whose data has not yet arrived.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_off  <= 2'b00;
            r_size <= 2'b00;
            r_uns  <= 1'b0;
            r_addr <= '0;
            r_wr   <= 1'b0;
        end else if (w_capture) begin
            r_off  <= alu_data[1:0];
            r_size <= load_size;
            r_uns  <= load_unsigned;
            r_addr <= rd_addr_in;
            r_wr   <= reg_write_in;
        end
    end

    // Register-file port: address/data hold between completions.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_we    <= 1'b0;
            rd_addr  <= '0;
            rd_data  <= '0;
            addr_err <= 1'b0;
        end else begin
            rd_we    <= w_done & w_wr & (w_addr != '0) & ~w_mis;
            addr_err <= w_done & w_mis;
            if (w_done) begin
                rd_addr <= w_addr;
                rd_data <= w_result;
            end
        end
    end

endmodule

// File: tb/tb_writeback_pipe.sv
// Bench for writeback_pipe: directed scenarios plus random traffic, checked by a
// scoreboard fed from a transaction-level reference model.
module tb_writeback_pipe;

    localparam bit BE = 1'b1;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] alu_data;
    logic        rd_data_sel;
    logic [1:0]  load_size;
    logic        load_unsigned;
    logic [4:0]  rd_addr_in;
    logic        reg_write_in;
    logic [31:0] mem_data;
    logic        mem_valid;
    logic        rd_we;
    logic [4:0]  rd_addr;
    logic [31:0] rd_data;
    logic        addr_err;

    writeback_pipe #(.ADDR_SIZE(5), .WORD_SIZE(32), .BIG_ENDIAN(1)) dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .alu_data(alu_data), .rd_data_sel(rd_data_sel), .load_size(load_size),
        .load_unsigned(load_unsigned), .rd_addr_in(rd_addr_in), .reg_write_in(reg_write_in),
        .mem_data(mem_data), .mem_valid(mem_valid), .rd_we(rd_we), .rd_addr(rd_addr),
        .rd_data(rd_data), .addr_err(addr_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic        err;
        logic [4:0]  addr;
        logic [31:0] data;
    } exp_t;

    typedef struct {
        logic [31:0] alu;
        logic        sel;
        logic [1:0]  sz;
        logic        uns;
        logic [4:0]  rd;
        logic        wr;
    } instr_t;

    exp_t   sb[$];
    int     n_checks = 0;
    int     n_fail   = 0;
    bit     pend     = 1'b0;
    instr_t pinstr;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
        end
    endtask

    // Memory-order view: byte k of the word is the byte at address offset k.
    function automatic logic [31:0] ref_load(input logic [31:0] w, input logic [1:0] o,
                                             input logic [1:0] sz, input logic uns);
        logic [7:0]  b [4];
        logic [7:0]  bt;
        logic [15:0] h;
        for (int k = 0; k < 4; k++) b[k] = BE ? w[31-8*k -: 8] : w[8*k +: 8];
        case (sz)
            2'd0: begin
                bt = b[o];
                return uns ? {24'h0, bt} : {{24{bt[7]}}, bt};
            end
            2'd1: begin
                h = BE ? {b[{o[1], 1'b0}], b[{o[1], 1'b1}]} : {b[{o[1], 1'b1}], b[{o[1], 1'b0}]};
                return uns ? {16'h0, h} : {{16{h[15]}}, h};
            end
            default: return w;
        endcase
    endfunction

    function automatic void complete(input instr_t t, input logic [31:0] md);
        exp_t       e;
        logic [1:0] o;
        logic       mis;
        o   = t.alu[1:0];
        mis = t.sel && ((t.sz == 2'd1 && o[0]) || (t.sz >= 2'd2 && o != 2'd0));
        e.err  = mis;
        e.we   = t.wr && (t.rd != 5'd0) && !mis;
        e.addr = t.rd;
        e.data = t.sel ? ref_load(md, o, t.sz, t.uns) : t.alu;
        if (e.we || e.err) sb.push_back(e);
    endfunction

    // Apply one cycle of inputs (called just after a rising edge), update the model.
    task automatic drive(input logic v, input logic fl, input logic sel, input logic mv,
                         input logic uns, input logic wr, input logic [1:0] sz,
                         input logic [4:0] rd, input logic [31:0] alu, input logic [31:0] md);
        instr_t t;
        in_valid = v; flush = fl; rd_data_sel = sel; mem_valid = mv; load_unsigned = uns;
        reg_write_in = wr; load_size = sz; rd_addr_in = rd; alu_data = alu; mem_data = md;
        t.alu = alu; t.sel = sel; t.sz = sz; t.uns = uns; t.rd = rd; t.wr = wr;
        chk("in_ready", 32'(in_ready), 32'(!pend));
        if (!pend) begin
            if (v && !fl) begin
                if (sel && !mv) begin
                    pend   = 1'b1;
                    pinstr = t;
                end else begin
                    complete(t, md);
                end
            end
        end else if (fl) begin
            pend = 1'b0;
        end else if (mv) begin
            complete(pinstr, md);
            pend = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic mv);
        drive(1'b0, 1'b0, 1'b0, mv, 1'b0, 1'b0, 2'd0, 5'd0, 32'h0, 32'hDEADBEEF);
    endtask

    // Monitor: every write pulse or error pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (!rst && (rd_we || addr_err)) begin
            if (sb.size() == 0) begin
                chk("sb_unexpected_event", {30'h0, rd_we, addr_err}, 32'h0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("sb_we", 32'(rd_we), 32'(e.we));
                chk("sb_err", 32'(addr_err), 32'(e.err));
                if (e.we) begin
                    chk("sb_addr", 32'(rd_addr), 32'(e.addr));
                    chk("sb_data", rd_data, e.data);
                end
            end
        end
    end

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; alu_data = '0; rd_data_sel = 1'b0;
        load_size = 2'd0; load_unsigned = 1'b0; rd_addr_in = '0; reg_write_in = 1'b0;
        mem_data = '0; mem_valid = 1'b0;
        #1;
        chk("reset_rd_we", 32'(rd_we), 32'h0);
        chk("reset_rd_addr", 32'(rd_addr), 32'h0);
        chk("reset_rd_data", rd_data, 32'h0);
        chk("reset_addr_err", 32'(addr_err), 32'h0);
        chk("reset_in_ready", 32'(in_ready), 32'h1);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;

        // ALU writeback
        drive(1, 0, 0, 0, 0, 1, 2'd2, 5'd5, 32'h12345678, 32'h0);
        chk("alu_we", 32'(rd_we), 32'h1);
        chk("alu_addr", 32'(rd_addr), 32'd5);
        chk("alu_data", rd_data, 32'h12345678);
        idle(1'b0);
        chk("alu_we_pulse", 32'(rd_we), 32'h0);

        // Byte loads, big-endian, data present
        drive(1, 0, 1, 1, 0, 1, 2'd0, 5'd3, 32'h0000_1000, 32'h80FF7F01);
        chk("lb_signed_o0", rd_data, 32'hFFFFFF80);
        drive(1, 0, 1, 1, 1, 1, 2'd0, 5'd4, 32'h0000_1002, 32'h80FF7F01);
        chk("lbu_o2", rd_data, 32'h0000007F);

        // Late half load at offset 2
        drive(1, 0, 1, 0, 0, 1, 2'd1, 5'd9, 32'h0000_2002, 32'h0);
        chk("wait_ready0", 32'(in_ready), 32'h0);
        idle(1'b0);
        idle(1'b0);
        drive(1, 0, 0, 1, 0, 1, 2'd0, 5'd1, 32'h0, 32'h0000F00D);
        chk("late_data", rd_data, 32'hFFFFF00D);
        chk("late_we", 32'(rd_we), 32'h1);
        chk("late_addr", 32'(rd_addr), 32'd9);
        chk("late_ready", 32'(in_ready), 32'h1);

        // Misaligned word load
        drive(1, 0, 1, 1, 0, 1, 2'd2, 5'd6, 32'h0000_1002, 32'h11223344);
        chk("mis_err", 32'(addr_err), 32'h1);
        chk("mis_we", 32'(rd_we), 32'h0);
        drive(1, 0, 0, 0, 0, 1, 2'd0, 5'd7, 32'hCAFE0001, 32'h0);
        chk("mis_err_pulse", 32'(addr_err), 32'h0);
        chk("after_mis_we", 32'(rd_we), 32'h1);
        chk("after_mis_data", rd_data, 32'hCAFE0001);

        // Flush in WAIT with simultaneous mem_valid
        drive(1, 0, 1, 0, 0, 1, 2'd2, 5'd8, 32'h0000_3000, 32'h0);
        drive(0, 1, 0, 1, 0, 0, 2'd0, 5'd0, 32'h0, 32'h55555555);
        chk("flush_we", 32'(rd_we), 32'h0);
        chk("flush_ready", 32'(in_ready), 32'h1);

        // Register 0 is never written
        drive(1, 0, 0, 0, 0, 1, 2'd0, 5'd0, 32'hABCD0000, 32'h0);
        chk("r0_we", 32'(rd_we), 32'h0);

        // Async reset between edges while waiting
        drive(1, 0, 1, 0, 0, 1, 2'd2, 5'd10, 32'h0000_4000, 32'h0);
        in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("arst_rd_data", rd_data, 32'h0);
        chk("arst_rd_addr", 32'(rd_addr), 32'h0);
        chk("arst_ready", 32'(in_ready), 32'h1);
        pend = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        drive(1, 0, 0, 0, 0, 1, 2'd0, 5'd11, 32'h0BADF00D, 32'h0);
        chk("post_rst_we", 32'(rd_we), 32'h1);
        chk("post_rst_data", rd_data, 32'h0BADF00D);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 9) == 0,
                  1'($urandom_range(0, 1)), $urandom_range(0, 9) < 4,
                  1'($urandom_range(0, 1)), $urandom_range(0, 7) != 0,
                  2'($urandom_range(0, 3)), 5'($urandom_range(0, 31)),
                  $urandom, $urandom);
        end
        idle(1'b1);
        idle(1'b1);
        idle(1'b0);
        chk("sb_drain", 32'(sb.size()), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
